// File: rtl/dplca_pkg.sv
// -----------------------------------------------------------------------------
// dplca_pkg
// Shared definitions for the D-PLCA TXOP tracker:
//   - TO table size and TO ID width
//   - tracker FSM encodings (IDLE / SYNC / TRACK)
//   - ON/OFF constants for the aging enable and the default aging window
//   - popcnt16: 16-bit population count helper used by the claim counter
// -----------------------------------------------------------------------------
package dplca_pkg;

  localparam int MAX_TXOP           = 256;
  localparam int TXOP_ID_W          = 8;
  localparam int AGE_CYCLES_DEFAULT = 16;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } dplca_state_e;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      s = s + {4'd0, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/dplca_popcount256.sv
// -----------------------------------------------------------------------------
// dplca_popcount256
// Two-stage pipelined population count of a 256-bit vector.
//   stage 1: sixteen 16-bit partial counts, registered
//   stage 2: sum of the partials, registered
// Ports:
//   clk    in   1    clock
//   rst_n  in   1    synchronous, active-low clear of both stages
//   data   in   256  vector to count
//   count  out  9    number of set bits in data, two clocks later
// -----------------------------------------------------------------------------
module dplca_popcount256
  import dplca_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] data,
  output logic [8:0]   count
);

  logic [16*5-1:0] part_next;
  logic [16*5-1:0] part_reg;
  logic [8:0]      sum_next;
  logic [8:0]      count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_part
      assign part_next[gi*5 +: 5] = popcnt16(data[gi*16 +: 16]);
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < 16; i++) begin
      sum_next = sum_next + {4'd0, part_reg[i*5 +: 5]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      part_reg  <= '0;
      count_reg <= '0;
    end else begin
      part_reg  <= part_next;
      count_reg <= sum_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dplca_txop_tracker.sv
// -----------------------------------------------------------------------------
// dplca_txop_tracker
// Watches PLCA transmit opportunities and builds the D-PLCA TXOP claim table
// consumed by the node-ID allocation FSM. A PLCA cycle runs from one BEACON to
// the next; at each BEACON the cycle is closed and the published outputs are
// refreshed one clock later.
//
// Optional feature: define DPLCA_CLAIM_COUNT_EN to add claim_count, the
// registered popcount of txop_claim_table (valid one clock after the update
// pulse).
//
// Ports:
//   clk                    in   1    clock
//   plca_reset_n           in   1    synchronous, active-low reset
//   plca_en                in   1    PLCA enabled
//   dplca_en               in   1    D-PLCA enabled
//   dplca_aging            in   1    aging enable from the allocation FSM
//   beacon_det             in   1    pulse at every BEACON (cycle start)
//   to_end                 in   1    pulse at the end of each TO
//   to_id                  in   8    ID of the ending TO
//   to_claimed             in   1    ending TO carried COMMIT or data
//   txop_claim_table       out  256  claimed TOs, current + previous window
//   dplca_txop_table_upd   out  1    pulse when the table was refreshed
//   dplca_new_age          out  1    pulse with upd at aging-window rollover
//   dplca_txop_id          out  8    highest claimed TO of last cycle
//   dplca_txop_node_count  out  8    highest TO ID of last cycle + 1 (sat.)
//   claim_count            out  9    (DPLCA_CLAIM_COUNT_EN only) table popcount
// -----------------------------------------------------------------------------
module dplca_txop_tracker #(
  parameter int AGE_CYCLES = dplca_pkg::AGE_CYCLES_DEFAULT,
  parameter int MAX_TXOP   = dplca_pkg::MAX_TXOP
) (
  input  logic                            clk,
  input  logic                            plca_reset_n,
  input  logic                            plca_en,
  input  logic                            dplca_en,
  input  logic                            dplca_aging,
  input  logic                            beacon_det,
  input  logic                            to_end,
  input  logic [dplca_pkg::TXOP_ID_W-1:0] to_id,
  input  logic                            to_claimed,
  output logic [MAX_TXOP-1:0]             txop_claim_table,
  output logic                            dplca_txop_table_upd,
  output logic                            dplca_new_age,
  output logic [dplca_pkg::TXOP_ID_W-1:0] dplca_txop_id,
  output logic [dplca_pkg::TXOP_ID_W-1:0] dplca_txop_node_count
`ifdef DPLCA_CLAIM_COUNT_EN
  ,
  output logic [8:0]                      claim_count
`endif
);

  import dplca_pkg::*;

  localparam int IDW = TXOP_ID_W;

  dplca_state_e        state_reg, state_next;
  logic [MAX_TXOP-1:0] cur_reg, cur_next;
  logic [MAX_TXOP-1:0] win_acc_reg, win_acc_next;
  logic [MAX_TXOP-1:0] win_prev_reg, win_prev_next;
  logic [MAX_TXOP-1:0] table_reg, table_next;
  logic [7:0]          age_reg, age_next;
  logic [IDW-1:0]      max_id_reg, max_id_next;
  logic [IDW-1:0]      max_claim_reg, max_claim_next;
  logic [IDW-1:0]      txop_id_reg, txop_id_next;
  logic [IDW-1:0]      node_count_reg, node_count_next;
  logic                upd_reg, upd_next;
  logic                new_age_reg, new_age_next;

  logic                enabled;
  logic                to_valid;
  logic [MAX_TXOP-1:0] cur_eff;
  logic [IDW-1:0]      max_id_eff;
  logic [IDW-1:0]      max_claim_eff;
  logic [MAX_TXOP-1:0] acc_new;
  logic [8:0]          age_inc;

  assign enabled  = plca_en & dplca_en;
  assign to_valid = to_end & (int'(to_id) < MAX_TXOP);

  // Cycle state with the TO ending in this clock already credited, so a TO
  // that ends together with the BEACON lands in the cycle being closed.
  always_comb begin
    cur_eff       = cur_reg;
    max_id_eff    = max_id_reg;
    max_claim_eff = max_claim_reg;
    if (to_valid) begin
      if (to_claimed) begin
        cur_eff[to_id] = 1'b1;
        if (to_id > max_claim_eff) max_claim_eff = to_id;
      end
      if (to_id > max_id_eff) max_id_eff = to_id;
    end
  end

  assign acc_new = win_acc_reg | cur_eff;
  assign age_inc = {1'b0, age_reg} + 9'd1;

  always_comb begin
    state_next      = state_reg;
    cur_next        = cur_reg;
    win_acc_next    = win_acc_reg;
    win_prev_next   = win_prev_reg;
    table_next      = table_reg;
    age_next        = age_reg;
    max_id_next     = max_id_reg;
    max_claim_next  = max_claim_reg;
    txop_id_next    = txop_id_reg;
    node_count_next = node_count_reg;
    upd_next        = 1'b0;
    new_age_next    = 1'b0;

    // With aging off the previous window is meaningless and the counter idles.
    if (dplca_aging == OFF) begin
      age_next      = '0;
      win_prev_next = '0;
    end

    case (state_reg)
      IDLE: begin
        if (enabled) state_next = SYNC;
      end
      SYNC: begin
        if (beacon_det) begin
          state_next     = TRACK;
          cur_next       = '0;
          max_id_next    = '0;
          max_claim_next = '0;
        end
      end
      TRACK: begin
        cur_next       = cur_eff;
        max_id_next    = max_id_eff;
        max_claim_next = max_claim_eff;
        if (beacon_det) begin
          table_next      = acc_new | ((dplca_aging == ON) ? win_prev_reg : '0);
          txop_id_next    = max_claim_eff;
          node_count_next = (max_id_eff == {IDW{1'b1}}) ? max_id_eff : max_id_eff + 1'b1;
          upd_next        = 1'b1;
          win_acc_next    = acc_new;
          if (dplca_aging == ON) begin
            if (age_inc == 9'(AGE_CYCLES)) begin
              win_prev_next = acc_new;
              win_acc_next  = '0;
              age_next      = '0;
              new_age_next  = 1'b1;
            end else begin
              age_next = age_inc[7:0];
            end
          end
          cur_next       = '0;
          max_id_next    = '0;
          max_claim_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Disabling behaves like a reset on the next clock.
    if (!enabled) begin
      state_next      = IDLE;
      cur_next        = '0;
      win_acc_next    = '0;
      win_prev_next   = '0;
      table_next      = '0;
      age_next        = '0;
      max_id_next     = '0;
      max_claim_next  = '0;
      txop_id_next    = '0;
      node_count_next = '0;
      upd_next        = 1'b0;
      new_age_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!plca_reset_n) begin
      state_reg      <= IDLE;
      cur_reg        <= '0;
      win_acc_reg    <= '0;
      win_prev_reg   <= '0;
      table_reg      <= '0;
      age_reg        <= '0;
      max_id_reg     <= '0;
      max_claim_reg  <= '0;
      txop_id_reg    <= '0;
      node_count_reg <= '0;
      upd_reg        <= 1'b0;
      new_age_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      win_acc_reg    <= win_acc_next;
      win_prev_reg   <= win_prev_next;
      table_reg      <= table_next;
      age_reg        <= age_next;
      max_id_reg     <= max_id_next;
      max_claim_reg  <= max_claim_next;
      txop_id_reg    <= txop_id_next;
      node_count_reg <= node_count_next;
      upd_reg        <= upd_next;
      new_age_reg    <= new_age_next;
    end
  end

  assign txop_claim_table      = table_reg;
  assign dplca_txop_table_upd  = upd_reg;
  assign dplca_new_age         = new_age_reg;
  assign dplca_txop_id         = txop_id_reg;
  assign dplca_txop_node_count = node_count_reg;

`ifdef DPLCA_CLAIM_COUNT_EN
  // Fed from table_next so the two pipeline stages line up with the table
  // register: the count settles one clock after the update pulse.
  logic [255:0] pc_in;
  logic         pc_rst_n;

  assign pc_in    = 256'(table_next);
  assign pc_rst_n = plca_reset_n & enabled;

  dplca_popcount256 u_popcount (
    .clk   (clk),
    .rst_n (pc_rst_n),
    .data  (pc_in),
    .count (claim_count)
  );
`endif

endmodule

// File: tb/tb_dplca_txop_tracker.sv
// -----------------------------------------------------------------------------
// tb_dplca_txop_tracker
// Directed scoreboard bench for dplca_txop_tracker (AGE_CYCLES = 2). Stimulus
// pushes the hand-computed expected update before each closing BEACON; the
// monitor pops and compares whenever the update pulse is seen.
// -----------------------------------------------------------------------------
module tb_dplca_txop_tracker;

  logic         clk = 1'b0;
  logic         plca_reset_n = 1'b0;
  logic         plca_en = 1'b0;
  logic         dplca_en = 1'b0;
  logic         dplca_aging = 1'b0;
  logic         beacon_det = 1'b0;
  logic         to_end = 1'b0;
  logic [7:0]   to_id = 8'd0;
  logic         to_claimed = 1'b0;
  logic [255:0] txop_claim_table;
  logic         dplca_txop_table_upd;
  logic         dplca_new_age;
  logic [7:0]   dplca_txop_id;
  logic [7:0]   dplca_txop_node_count;
`ifdef DPLCA_CLAIM_COUNT_EN
  logic [8:0]   claim_count;
`endif

  always #5 clk = ~clk;

  dplca_txop_tracker #(.AGE_CYCLES(2), .MAX_TXOP(256)) dut (
    .clk                   (clk),
    .plca_reset_n          (plca_reset_n),
    .plca_en               (plca_en),
    .dplca_en              (dplca_en),
    .dplca_aging           (dplca_aging),
    .beacon_det            (beacon_det),
    .to_end                (to_end),
    .to_id                 (to_id),
    .to_claimed            (to_claimed),
    .txop_claim_table      (txop_claim_table),
    .dplca_txop_table_upd  (dplca_txop_table_upd),
    .dplca_new_age         (dplca_new_age),
    .dplca_txop_id         (dplca_txop_id),
    .dplca_txop_node_count (dplca_txop_node_count)
`ifdef DPLCA_CLAIM_COUNT_EN
    ,
    .claim_count           (claim_count)
`endif
  );

  typedef struct {
    logic [255:0] tbl;
    logic [7:0]   id;
    logic [7:0]   cnt;
    logic         na;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_upd = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic beacon();
    beacon_det = 1'b1;
    clk1();
    beacon_det = 1'b0;
  endtask

  task automatic to(input int id, input bit claimed);
    to_end     = 1'b1;
    to_id      = 8'(id);
    to_claimed = claimed;
    clk1();
    to_end     = 1'b0;
    to_claimed = 1'b0;
  endtask

  task automatic push(input logic [255:0] tbl, input int id, input int cnt, input bit na);
    exp_t e;
    e.tbl = tbl;
    e.id  = 8'(id);
    e.cnt = 8'(cnt);
    e.na  = na;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_table"}, txop_claim_table, '0);
    chk({tag, "_upd"}, 256'(dplca_txop_table_upd), '0);
    chk({tag, "_new_age"}, 256'(dplca_new_age), '0);
    chk({tag, "_txop_id"}, 256'(dplca_txop_id), '0);
    chk({tag, "_node_count"}, 256'(dplca_txop_node_count), '0);
`ifdef DPLCA_CLAIM_COUNT_EN
    chk({tag, "_claim_count"}, 256'(claim_count), '0);
`endif
  endtask

  task automatic reenable();
    plca_en = 1'b0;
    clk1();
    plca_en = 1'b1;
    clk1();
    clk1();
  endtask

  // Monitor: one compare line per published update.
  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      if (dplca_txop_table_upd === 1'b1) begin
        n_upd++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_upd #%0d act=upd req=none", n_upd);
        end else begin
          m = sb.pop_front();
          $display("upd #%0d table=%h id=%0d cnt=%0d na=%0d",
                   n_upd, txop_claim_table, dplca_txop_id, dplca_txop_node_count, dplca_new_age);
          chk($sformatf("upd%0d_table", n_upd), txop_claim_table, m.tbl);
          chk($sformatf("upd%0d_txop_id", n_upd), 256'(dplca_txop_id), 256'(m.id));
          chk($sformatf("upd%0d_node_count", n_upd), 256'(dplca_txop_node_count), 256'(m.cnt));
          chk($sformatf("upd%0d_new_age", n_upd), 256'(dplca_new_age), 256'(m.na));
`ifdef DPLCA_CLAIM_COUNT_EN
          @(negedge clk);
          chk($sformatf("upd%0d_claim_count", n_upd), 256'(claim_count), 256'($countones(m.tbl)));
`endif
        end
      end else if (dplca_new_age === 1'b1) begin
        n_err++;
        $display("FAIL new_age_without_upd act=1 req=0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] t;
    int id;

    // Reset state.
    plca_en  = 1'b1;
    dplca_en = 1'b1;
    repeat (3) clk1();
    check_zero("reset");
    plca_reset_n = 1'b1;
    clk1();
    clk1();

    // Basic cycle: claims on 0, 3, 5; highest TO 7.
    dplca_aging = 1'b1;
    beacon();
    to(0, 1); to(1, 0); to(3, 1); to(5, 1); to(7, 0);
    t = '0; t[0] = 1'b1; t[3] = 1'b1; t[5] = 1'b1;
    push(t, 5, 8, 0);
    beacon();
    clk1();
    plca_en = 1'b0;
    clk1();
    check_zero("disable1");

    // Aging with a 2-cycle window: claim TO 4 in cycle 1 only.
    plca_en = 1'b1;
    clk1(); clk1();
    beacon();
    to(4, 1); to(2, 0);
    t = '0; t[4] = 1'b1;
    push(t, 4, 5, 0); beacon();
    to(1, 0);  push(t, 0, 2, 1); beacon();
    to(0, 0);  push(t, 0, 1, 0); beacon();
    to(0, 0);  push(t, 0, 1, 1); beacon();
    to(0, 0);  push('0, 0, 1, 0); beacon();
    to(0, 0);  push('0, 0, 1, 1); beacon();
    clk1();

    // TO ending together with the BEACON belongs to the closing cycle.
    dplca_aging = 1'b0;
    reenable();
    beacon();
    to(2, 1);
    t = '0; t[2] = 1'b1; t[9] = 1'b1;
    push(t, 9, 10, 0);
    beacon_det = 1'b1; to_end = 1'b1; to_id = 8'd9; to_claimed = 1'b1;
    clk1();
    beacon_det = 1'b0; to_end = 1'b0; to_claimed = 1'b0;
    to(3, 0);
    push(t, 0, 4, 0);
    beacon();

    // Disable mid-cycle; claims before the first BEACON are discarded.
    to(6, 1);
    plca_en = 1'b0;
    clk1();
    check_zero("disable2");
    plca_en = 1'b1;
    to(20, 1); to(21, 1);
    beacon();
    to(30, 1);
    t = '0; t[30] = 1'b1;
    push(t, 30, 31, 0);
    beacon();

    // Aging off for 40 cycles: table accumulates, new_age stays low.
    for (int k = 0; k < 40; k++) begin
      id = k * 6;
      to(id, 1);
      t[id] = 1'b1;
      if (k == 39) begin
        to(255, 0);
        push(t, id, 255, 0);
      end else begin
        push(t, id, id + 1, 0);
      end
      beacon();
    end
    clk1();

    // Table {1, 2, 200}.
    reenable();
    beacon();
    to(1, 1); to(2, 1); to(200, 1);
    t = '0; t[1] = 1'b1; t[2] = 1'b1; t[200] = 1'b1;
    push(t, 200, 201, 0);
    beacon();

    // Drain the scoreboard within a bounded number of clocks.
    for (int w = 0; w < 20 && sb.size() != 0; w++) clk1();
    repeat (4) clk1();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain act=%0d req=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
